// File: rtl/gf2m_kara_mul_pipe.sv
// gf2m_kara_mul_pipe: three-stage GF(2^M) multiplier using one-level Karatsuba and pentanomial reduction.
// Supports multiply, square and multiply-add, with a valid/ready handshake and full backpressure.
module gf2m_kara_mul_pipe #(
   parameter int M  = 16,
   parameter int K3 = 5,
   parameter int K2 = 3,
   parameter int K1 = 2
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [M-1:0] a_in,
   input  logic [M-1:0] b_in,
   input  logic [M-1:0] d_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] c_out
);
   localparam int H = M / 2;
   localparam int P = 2 * H - 1;

   logic         en;
   logic         v1_q, v2_q, out_valid_q, mad1_q, mad2_q;
   logic [H-1:0] ah_q, al_q, bh_q, bl_q, as_q, bs_q;
   logic [M-1:0] d1_q, d2_q, c_q, c_d, b_d;
   logic [P-1:0] z0_q, z1_q, z2_q;
   logic [2*M-2:0] prod;

   function automatic logic [P-1:0] clmul(input logic [H-1:0] x, input logic [H-1:0] y);
      logic [P-1:0] r;
      r = '0;
      for (int i = 0; i < H; i++)
         if (y[i]) r = r ^ (P'(x) << i);
      return r;
   endfunction

   // Fold from the top down so every bit toggled lands strictly below the one cleared.
   function automatic logic [M-1:0] reduce(input logic [2*M-2:0] p);
      logic [2*M-2:0] r;
      r = p;
      for (int j = 2*M-2; j >= M; j--)
         if (r[j]) begin
            r[j]        = 1'b0;
            r[j-M+K3]   = ~r[j-M+K3];
            r[j-M+K2]   = ~r[j-M+K2];
            r[j-M+K1]   = ~r[j-M+K1];
            r[j-M]      = ~r[j-M];
         end
      return r[M-1:0];
   endfunction

   assign en        = !(out_valid_q && !out_ready);
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign c_out     = c_q;

   always_comb begin
      b_d  = (op == 2'b01) ? a_in : b_in;
      prod = {z2_q, {M{1'b0}}} ^ {{H{1'b0}}, z1_q ^ z0_q ^ z2_q, {H{1'b0}}} ^ {{M{1'b0}}, z0_q};
      c_d  = reduce(prod) ^ (mad2_q ? d2_q : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         mad1_q      <= 1'b0;
         mad2_q      <= 1'b0;
         ah_q        <= '0;
         al_q        <= '0;
         bh_q        <= '0;
         bl_q        <= '0;
         as_q        <= '0;
         bs_q        <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         z0_q        <= '0;
         z1_q        <= '0;
         z2_q        <= '0;
         c_q         <= '0;
      end else if (en) begin
         v1_q        <= in_valid;
         mad1_q      <= (op == 2'b10);
         ah_q        <= a_in[M-1:H];
         al_q        <= a_in[H-1:0];
         bh_q        <= b_d[M-1:H];
         bl_q        <= b_d[H-1:0];
         as_q        <= a_in[M-1:H] ^ a_in[H-1:0];
         bs_q        <= b_d[M-1:H] ^ b_d[H-1:0];
         d1_q        <= d_in;
         v2_q        <= v1_q;
         mad2_q      <= mad1_q;
         d2_q        <= d1_q;
         z2_q        <= clmul(ah_q, bh_q);
         z0_q        <= clmul(al_q, bl_q);
         z1_q        <= clmul(as_q, bs_q);
         out_valid_q <= v2_q;
         if (v2_q) c_q <= c_d;
      end
   end
endmodule

// File: tb/tb_gf2m_kara_mul_pipe.sv
// tb_gf2m_kara_mul_pipe: directed and randomized checks of the GF(2^16) pipelined multiplier
// against a shift-and-reduce reference model.
module tb_gf2m_kara_mul_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [1:0]  op = 2'b00;
   logic [15:0] a_in = '0, b_in = '0, d_in = '0;
   logic        in_ready, out_valid;
   logic [15:0] c_out;
   int          errors = 0;
   int          checks = 0;

   gf2m_kara_mul_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a_in(a_in), .b_in(b_in), .d_in(d_in), .out_valid(out_valid),
      .out_ready(out_ready), .c_out(c_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r, s;
      r = '0;
      s = a;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) r = r ^ s;
         s = s[15] ? ((s << 1) ^ 16'h002D) : (s << 1);
      end
      return r;
   endfunction

   function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
      logic [15:0] r;
      r = (o == 2'b01) ? gf_mul(a, a) : gf_mul(a, b);
      return (o == 2'b10) ? (r ^ d) : r;
   endfunction

   task automatic single(input string name, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] d, input logic [15:0] exp);
      out_ready = 1'b1;
      op = o; a_in = a; b_in = b; d_in = d; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b want 1", name, in_ready); end
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early out_valid at cycle %0d: got %b want 0", name, k + 1, out_valid); end
         step();
      end
      checks++;
      if (out_valid !== 1'b1 || c_out !== exp) begin
         errors++;
         $display("FAIL %s result: out_valid=%b c_out=%h want out_valid=1 c_out=%h", name, out_valid, c_out, exp);
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || c_out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b c_out=%h want 0/0000", out_valid, c_out);
      end
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      single("mul_x8_x8",   2'b00, 16'h0100, 16'h0100, 16'h0000, 16'h002D);
      single("mul_by_one",  2'b00, 16'hBEEF, 16'h0001, 16'h0000, 16'hBEEF);
      single("mul_by_zero", 2'b00, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
      single("square_x15",  2'b01, 16'h8000, 16'h1234, 16'h0000, 16'h411F);
      single("reserved_op", 2'b11, 16'h0100, 16'h0100, 16'hFFFF, 16'h002D);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      op = 2'b10; a_in = 16'h0100; b_in = 16'h0100; d_in = 16'h002D; in_valid = 1'b1;
      step();
      d_in = 16'hFFFF;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early: out_valid=%b want 0", out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1 || c_out !== 16'h0000) begin
         errors++; $display("FAIL b2b_first: out_valid=%b c_out=%h want 1/0000", out_valid, c_out);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || c_out !== 16'hFFD2) begin
         errors++; $display("FAIL b2b_second: out_valid=%b c_out=%h want 1/ffd2", out_valid, c_out);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_q[$];
      logic [15:0] c_prev;
      logic        stall_prev;
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; c_prev = '0;
      while (got < 6 && cyc < 200) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (sent < 6) begin
            in_valid = 1'b1;
            op   = 2'($urandom_range(0, 3));
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            d_in = 16'($urandom);
         end else in_valid = 1'b0;
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp_in_ready cycle %0d: got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
         end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || c_out !== c_prev) begin
               errors++;
               $display("FAIL bp_stall_hold cycle %0d: out_valid=%b c_out=%h want 1/%h", cyc, out_valid, c_out, c_prev);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_result cycle %0d: c_out=%h with nothing expected", cyc, c_out);
            end else begin
               if (c_out !== exp_q[0]) begin
                  errors++;
                  $display("FAIL bp_result %0d: got %h want %h", got, c_out, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(op, a_in, b_in, d_in));
            sent++;
         end
         stall_prev = out_valid && !out_ready;
         c_prev = c_out;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 6 || sent != 6) begin
         errors++;
         $display("FAIL bp_count: sent=%0d received=%0d want 6/6", sent, got);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate cycle %0d: out_valid=%b want 0", k, out_valid); end
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] a, b, d;
      out_ready = 1'b1;
      op = 2'b00; a_in = 16'h0100; b_in = 16'h0100; in_valid = 1'b1;
      step();
      a_in = 16'hBEEF; b_in = 16'h0001;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || c_out !== 16'h0000) begin
         errors++;
         $display("FAIL midrst_clear: out_valid=%b c_out=%h want 0/0000", out_valid, c_out);
      end
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d: out_valid=%b want 0", k, out_valid); end
         step();
      end
      a = 16'($urandom); b = 16'($urandom); d = 16'($urandom);
      single("post_reset", 2'b10, a, b, d, model(2'b10, a, b, d));
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
